// File: rtl/sll_iter_pkg.sv
// Shared constants and state encoding for the iterative 32-bit left shifter.
package sll_iter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sll_iter_if.sv
// Start / result-ready handshake shared with the multiplier/divider units.
interface sll_iter_if;
  import sll_iter_pkg::*;

  logic               ctrl_shift;
  logic [WIDTH-1:0]   data_operand;
  logic [SHAMT_W-1:0] data_shamt;
  logic [WIDTH-1:0]   data_result;
  logic               data_exception;
  logic               data_resultRDY;
  logic               ctrl_busy;

  modport master (
    output ctrl_shift, data_operand, data_shamt,
    input  data_result, data_exception, data_resultRDY, ctrl_busy
  );

  modport slave (
    input  ctrl_shift, data_operand, data_shamt,
    output data_result, data_exception, data_resultRDY, ctrl_busy
  );

endinterface

// File: rtl/sll_iter_sl_stage.sv
// Conditional left shift by the constant N, reporting whether any 1-bit falls off the top.
module sl_stage
  import sll_iter_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             lost
);

  assign out  = enable ? (in << N) : in;
  assign lost = enable & (|in[WIDTH-1 -: N]);

endmodule

// File: rtl/sll_iter.sv
// Multicycle logical left shifter: one power-of-two stage per cycle, LSB of shamt first.
//
// state    | meaning
// ST_IDLE  | waiting for ctrl_shift; outputs hold the last result
// ST_SHIFT | applying stage cnt_q (shift by 2^cnt_q if shamt bit set)
// ST_DONE  | result valid for one cycle; may accept the next operation
module sll_iter
  import sll_iter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  sll_iter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               exc_q, exc_d;

  logic [WIDTH-1:0]   stg_out [SHAMT_W];
  logic [SHAMT_W-1:0] stg_lost;
  logic [WIDTH-1:0]   sel_out;
  logic               sel_lost;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    sl_stage #(.N(1 << g)) u_stage (
      .in     (work_q),
      .enable (shamt_q[g]),
      .out    (stg_out[g]),
      .lost   (stg_lost[g])
    );
  end

  always_comb begin
    sel_out  = work_q;
    sel_lost = 1'b0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sel_out  = stg_out[i];
        sel_lost = stg_lost[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    exc_d   = exc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.ctrl_shift) begin
          work_d  = bus.data_operand;
          shamt_d = bus.data_shamt;
          exc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = sel_out;
        exc_d  = exc_q | sel_lost;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHAMT_W - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      shamt_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.data_result    = work_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.ctrl_busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_sll_iter.sv
// Directed and random checks of the iterative left shifter against a 64-bit reference.
module tb_sll_iter;
  import sll_iter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  sll_iter_if bus ();

  sll_iter dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Full transaction: accept, scramble inputs, wait bounded for RDY, check latency/result/hold.
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh,
                        input logic [31:0] exp_r, input logic exp_e,
                        input bit pulse, input string tag);
    int lat;
    bit busy_ok;
    bus.ctrl_shift   = 1'b1;
    bus.data_operand = op;
    bus.data_shamt   = sh;
    step();
    bus.ctrl_shift   = 1'b0;
    bus.data_operand = $urandom;
    bus.data_shamt   = 5'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.data_resultRDY && lat < 20) begin
      if (!bus.ctrl_busy) busy_ok = 1'b0;
      bus.ctrl_shift = (pulse && lat == 1);
      step();
      lat++;
    end
    bus.ctrl_shift = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, " result"}, bus.data_result, exp_r);
    chk({tag, " exception"}, {31'd0, bus.data_exception}, {31'd0, exp_e});
    chk({tag, " busy at done"}, {31'd0, bus.ctrl_busy}, 32'd0);
    step();
    chk({tag, " rdy one cycle"}, {31'd0, bus.data_resultRDY}, 32'd0);
    chk({tag, " result hold"}, bus.data_result, exp_r);
  endtask

  initial begin
    logic [63:0] wide;
    logic [31:0] r_op;
    logic [4:0]  r_sh;
    int          gap;
    int          rdy_seen;

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.ctrl_shift = 1'b0;
    bus.data_operand = '0;
    bus.data_shamt = '0;
    step();
    step();
    chk("reset result", bus.data_result, 32'd0);
    chk("reset exception", {31'd0, bus.data_exception}, 32'd0);
    chk("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, bus.ctrl_busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-shift discards the operation and clears outputs asynchronously.
    bus.ctrl_shift = 1'b1;
    bus.data_operand = 32'hFFFF_FFFF;
    bus.data_shamt = 5'd3;
    step();
    bus.ctrl_shift = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset result", bus.data_result, 32'd0);
    chk("midreset exception", {31'd0, bus.data_exception}, 32'd0);
    chk("midreset busy", {31'd0, bus.ctrl_busy}, 32'd0);
    chk("midreset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    step();
    rst_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_resultRDY || bus.ctrl_busy) rdy_seen++;
    end
    chk("midreset no rdy", 32'(rdy_seen), 32'd0);

    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0, "basic31");
    run_op(32'h1234_5678, 5'd4,  32'h2345_6780, 1'b1, 1'b0, "ovf4");
    run_op(32'h0FFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b0, 1'b0, "noovf4");
    run_op(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, "zero");
    run_op(32'h0000_00FF, 5'd24, 32'hFF00_0000, 1'b0, 1'b1, "pulse24");
    run_op(32'h0000_0180, 5'd25, 32'h0000_0000, 1'b1, 1'b1, "pulse25");

    // Back-to-back with ctrl_shift held high: second op accepted in DONE, RDY every 6 cycles.
    bus.ctrl_shift = 1'b1;
    bus.data_operand = 32'h1234_5678;
    bus.data_shamt = 5'd4;
    step();
    bus.data_operand = 32'h0000_00FF;
    bus.data_shamt = 5'd8;
    gap = 0;
    while (!bus.data_resultRDY && gap < 20) begin
      step();
      gap++;
    end
    chk("b2b first latency", 32'(gap), 32'd5);
    chk("b2b first result", bus.data_result, 32'h2345_6780);
    chk("b2b first exception", {31'd0, bus.data_exception}, 32'd1);
    step();
    bus.data_operand = 32'hFFFF_FFFF;
    bus.data_shamt = 5'd1;
    chk("b2b second busy", {31'd0, bus.ctrl_busy}, 32'd1);
    gap = 1;
    while (!bus.data_resultRDY && gap < 20) begin
      step();
      gap++;
    end
    bus.ctrl_shift = 1'b0;
    chk("b2b rdy period", 32'(gap), 32'd6);
    chk("b2b second result", bus.data_result, 32'h0000_FF00);
    chk("b2b second exception", {31'd0, bus.data_exception}, 32'd0);
    step();
    step();
    chk("b2b ends idle", {31'd0, bus.ctrl_busy}, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      r_op = $urandom;
      r_sh = 5'($urandom);
      if (i % 4 == 0) r_op = r_op >> $urandom_range(0, 31);
      wide = {32'd0, r_op} << r_sh;
      run_op(r_op, r_sh, wide[31:0], (wide[63:32] != 32'd0), (i % 3 == 0), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
